// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the ID-stage hazard inputs and the stall/flush sequencer outputs.
// master = pipeline/ID side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic                   ex_mem_read;
    logic [4:0]             ex_rd;
    logic                   id_md_start;
    logic                   branch_taken;
    logic                   imem_ready;
    logic                   pc_stall;
    logic                   ifid_stall;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   md_busy;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               id_md_start, branch_taken, imem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, state, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               id_md_start, branch_taken, imem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// multi-cycle mul/div occupancy and instruction-fetch wait states.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LATENCY  = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int unsigned CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        IF_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   load_use;
    logic                   pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

    always_comb begin
        pc_stall_c   = 1'b0;
        ifid_stall_c = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;

        case (state_q)
            RUN: begin
                if (load_use) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (hz.branch_taken) begin
                    ifid_flush_c = 1'b1;
                end else if (hz.id_md_start) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = MD_LAST;
                end else if (!hz.imem_ready) begin
                    pc_stall_c   = 1'b1;
                    ifid_flush_c = 1'b1;
                    state_d      = IF_WAIT;
                end
            end
            MD_WAIT: begin
                pc_stall_c   = 1'b1;
                ifid_stall_c = 1'b1;
                idex_flush_c = 1'b1;
                if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            IF_WAIT: begin
                if (hz.imem_ready) begin
                    state_d = RUN;
                end else begin
                    pc_stall_c   = 1'b1;
                    ifid_flush_c = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset overrides everything: flush both latches, never hold the PC.
        if (clr) begin
            pc_stall_c   = 1'b0;
            ifid_stall_c = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = RUN;
            md_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (pc_stall_c && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.ifid_stall   = ifid_stall_c;
    assign hz.ifid_flush   = ifid_flush_c;
    assign hz.idex_flush   = idex_flush_c;
    assign hz.md_busy      = (state_q == MD_WAIT);
    assign hz.state        = state_q;
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: scoreboarded per-cycle control outputs
// plus a stall-counter model, on a default instance and a narrow-counter / MD_LATENCY=1 instance.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic clr;
    logic clr_s;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(16)) hif ();
    pipeline_hazard_ctrl_if #(.STALL_CNT_W(4))  hif_s ();

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .clr (clr),
        .hz  (hif)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(1), .STALL_CNT_W(4)) dut_s (
        .clk (clk),
        .clr (clr_s),
        .hz  (hif_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, state[1:0]}
    logic [6:0] obs, obs_s;
    assign obs   = {hif.pc_stall, hif.ifid_stall, hif.ifid_flush, hif.idex_flush,
                    hif.md_busy, hif.state};
    assign obs_s = {hif_s.pc_stall, hif_s.ifid_stall, hif_s.ifid_flush, hif_s.idex_flush,
                    hif_s.md_busy, hif_s.state};

    localparam logic [6:0] IDLE     = 7'b0000_0_00;
    localparam logic [6:0] STALL_LU = 7'b1101_0_00;
    localparam logic [6:0] BR       = 7'b0010_0_00;
    localparam logic [6:0] IFW_RUN  = 7'b1010_0_00;
    localparam logic [6:0] IFW      = 7'b1010_0_10;
    localparam logic [6:0] IFW_DONE = 7'b0000_0_10;
    localparam logic [6:0] MDW      = 7'b1101_1_01;
    localparam logic [6:0] CLR_RUN  = 7'b0011_0_00;
    localparam logic [6:0] CLR_MD   = 7'b0011_1_01;
    localparam logic [6:0] CLR_IFW  = 7'b0011_0_10;

    typedef struct packed {
        logic       clr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] rd;
        logic       md;
        logic       br;
        logic       ir;
        logic [6:0] exp;
    } vec_t;

    logic [6:0]  sb_q[$];
    int          n_checks;
    int          n_err;
    logic [15:0] exp_stalls;
    logic [3:0]  exp_stalls_s;

    function automatic vec_t mk(input logic c, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic mr,
                                input logic [4:0] rd, input logic md, input logic br,
                                input logic ir, input logic [6:0] e);
        vec_t v;
        v.clr = c; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
        v.rd = rd; v.md = md; v.br = br; v.ir = ir; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        clr              = v.clr;
        hif.id_rs        = v.rs;
        hif.id_rt        = v.rt;
        hif.id_uses_rs   = v.urs;
        hif.id_uses_rt   = v.urt;
        hif.ex_mem_read  = v.mr;
        hif.ex_rd        = v.rd;
        hif.id_md_start  = v.md;
        hif.branch_taken = v.br;
        hif.imem_ready   = v.ir;
    endtask

    task automatic drive_s(input vec_t v);
        clr_s              = v.clr;
        hif_s.id_rs        = v.rs;
        hif_s.id_rt        = v.rt;
        hif_s.id_uses_rs   = v.urs;
        hif_s.id_uses_rt   = v.urt;
        hif_s.ex_mem_read  = v.mr;
        hif_s.ex_rd        = v.rd;
        hif_s.id_md_start  = v.md;
        hif_s.branch_taken = v.br;
        hif_s.imem_ready   = v.ir;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, CLR_RUN));
        sb_q.push_back(CLR_RUN);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_err++; $display("FAIL reset_during_clr: outputs got %b want %b", obs, e);
        end
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE));
        sb_q.push_back(IDLE);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_err++; $display("FAIL reset_after_clr: outputs got %b want %b", obs, e);
        end
        n_checks++;
        if (hif.stall_cycles !== 16'd0) begin
            n_err++; $display("FAIL reset_stall_cycles: got %0d want 0", hif.stall_cycles);
        end
        exp_stalls = '0;
    endtask

    task automatic test_load_use();
        vec_t t[8];
        logic [6:0] e;
        t[0] = mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 1, STALL_LU);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[2] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, IDLE);
        t[3] = mk(0, 3, 5, 0, 1, 1, 5, 0, 0, 1, STALL_LU);
        t[4] = mk(0, 5, 5, 0, 0, 1, 5, 0, 0, 1, IDLE);
        t[5] = mk(0, 8, 0, 1, 0, 0, 8, 0, 0, 1, IDLE);
        t[6] = mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, STALL_LU);
        t[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++; $display("FAIL load_use[%0d]: outputs got %b want %b", i, obs, e);
            end
            n_checks++;
            if (hif.stall_cycles !== exp_stalls) begin
                n_err++; $display("FAIL load_use_cnt[%0d]: got %0d want %0d", i, hif.stall_cycles, exp_stalls);
            end
            if (e[6]) exp_stalls++;
        end
    endtask

    task automatic test_md();
        vec_t t[6];
        logic [6:0] e;
        t[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, IDLE);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDW);
        t[2] = mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 1, MDW);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MDW);
        t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++; $display("FAIL md_wait[%0d]: outputs got %b want %b", i, obs, e);
            end
            n_checks++;
            if (hif.stall_cycles !== exp_stalls) begin
                n_err++; $display("FAIL md_wait_cnt[%0d]: got %0d want %0d", i, hif.stall_cycles, exp_stalls);
            end
            if (e[6]) exp_stalls++;
        end
    endtask

    task automatic test_fetch_wait();
        vec_t t[5];
        logic [6:0] e;
        t[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW_RUN);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW);
        t[2] = mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 0, IFW);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IFW_DONE);
        t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++; $display("FAIL fetch_wait[%0d]: outputs got %b want %b", i, obs, e);
            end
            n_checks++;
            if (hif.stall_cycles !== exp_stalls) begin
                n_err++; $display("FAIL fetch_wait_cnt[%0d]: got %0d want %0d", i, hif.stall_cycles, exp_stalls);
            end
            if (e[6]) exp_stalls++;
        end
    endtask

    task automatic test_priority();
        vec_t t[14];
        logic [6:0] e;
        t[0]  = mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 1, STALL_LU);
        t[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BR);
        t[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BR);
        t[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR);
        t[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[6]  = mk(0, 0, 9, 0, 1, 1, 9, 1, 0, 1, STALL_LU);
        t[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, IDLE);
        t[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++; $display("FAIL priority[%0d]: outputs got %b want %b", i, obs, e);
            end
            n_checks++;
            if (hif.stall_cycles !== exp_stalls) begin
                n_err++; $display("FAIL priority_cnt[%0d]: got %0d want %0d", i, hif.stall_cycles, exp_stalls);
            end
            if (e[6]) exp_stalls++;
        end
    endtask

    task automatic test_clr_abort();
        vec_t t[8];
        logic [6:0] e;
        t[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, IDLE);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, CLR_MD);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW_RUN);
        t[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW);
        t[6] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CLR_IFW);
        t[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++; $display("FAIL clr_abort[%0d]: outputs got %b want %b", i, obs, e);
            end
            n_checks++;
            if (hif.stall_cycles !== exp_stalls) begin
                n_err++; $display("FAIL clr_abort_cnt[%0d]: got %0d want %0d", i, hif.stall_cycles, exp_stalls);
            end
            if (t[i].clr) exp_stalls = '0;
            else if (e[6]) exp_stalls++;
        end
    endtask

    // Narrow counter saturation and the single-cycle MD_LATENCY=1 corner.
    task automatic test_saturate();
        vec_t t[26];
        logic [6:0] e;
        t[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, CLR_RUN);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, IDLE);
        t[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW_RUN);
        for (int k = 5; k < 24; k++) t[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFW);
        t[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IFW_DONE);
        t[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        exp_stalls_s = '0;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            drive_s(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_err++; $display("FAIL saturate[%0d]: outputs got %b want %b", i, obs_s, e);
            end
            n_checks++;
            if (hif_s.stall_cycles !== exp_stalls_s) begin
                n_err++; $display("FAIL saturate_cnt[%0d]: got %0d want %0d", i, hif_s.stall_cycles, exp_stalls_s);
            end
            if (t[i].clr) exp_stalls_s = '0;
            else if (e[6] && exp_stalls_s != 4'hF) exp_stalls_s++;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        exp_stalls   = '0;
        exp_stalls_s = '0;
        drive_s(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE));
        test_reset();
        test_load_use();
        test_md();
        test_fetch_wait();
        test_priority();
        test_clr_abort();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
